execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 179 +++++++++++++++++
 tb/tb_execute_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Single-issue execute stage: decodes one instruction, drives an external ALU
// from registers and returns the result through a valid/ready output handshake.
module execute_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic [4:0]   rd,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic [N-1:0] imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  input  logic         alu_equal,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [4:0]   out_rd,
  output logic         out_wr_en,
  output logic         out_branch_taken,
  output logic         out_overflow,
  output logic         out_illegal,
  output logic [15:0]  retired_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
  typedef enum logic [1:0] {K_ILL, K_ALU, K_BR} kind_t;
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,  OP_AND = 4'd1,  OP_OR  = 4'd2,  OP_XOR  = 4'd3,
    OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7,  OP_ADD  = 4'd8,
    OP_SUB  = 4'd12, OP_SLT = 4'd13, OP_SLTU = 4'd15
  } alu_op_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  state_t         r_state;
  kind_t          r_kind;
  alu_op_t        r_alu_control;
  logic [2:0]     r_funct3;
  logic [4:0]     r_rd;
  logic [N-1:0]   r_alu_a, r_alu_b;
  logic [N-1:0]   r_out_result;
  logic [4:0]     r_out_rd;
  logic           r_out_valid, r_out_wr_en, r_out_taken, r_out_overflow, r_out_illegal;
  logic [15:0]    r_retired;

  kind_t          w_kind;
  alu_op_t        w_ctrl;
  logic [N-1:0]   w_b;
  logic           w_taken;
  logic           w_unused;

  // The zero flag carries no information this stage needs beyond alu_equal.
  assign w_unused = alu_zero;

  function automatic alu_op_t alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? OP_SUB : OP_ADD;
      3'b001:  alu_fn = OP_SLL;
      3'b010:  alu_fn = OP_SLT;
      3'b011:  alu_fn = OP_SLTU;
      3'b100:  alu_fn = OP_XOR;
      3'b101:  alu_fn = alt ? OP_SRA : OP_SRL;
      3'b110:  alu_fn = OP_OR;
      default: alu_fn = OP_AND;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_kind = K_ILL;
    w_ctrl = OP_NONE;
    w_b    = '0;
    case (opcode)
      OPC_R: begin
        w_kind = K_ALU;
        w_ctrl = alu_fn(funct3, funct7_5);
        w_b    = rs2_data;
      end
      OPC_I: begin
        w_kind = K_ALU;
        w_ctrl = alu_fn(funct3, funct7_5 && (funct3 == 3'b101));
        w_b    = imm;
      end
      OPC_B: begin
        case (funct3)
          3'b000, 3'b001: begin w_kind = K_BR; w_ctrl = OP_SUB;  w_b = rs2_data; end
          3'b100, 3'b101: begin w_kind = K_BR; w_ctrl = OP_SLT;  w_b = rs2_data; end
          3'b110, 3'b111: begin w_kind = K_BR; w_ctrl = OP_SLTU; w_b = rs2_data; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // funct3[0] selects the inverted sense (BNE/BGE/BGEU) of each branch pair.
  always_comb begin
    w_taken = 1'b0;
    if (r_kind == K_BR) begin
      if (r_funct3[2:1] == 2'b00) w_taken = alu_equal ^ r_funct3[0];
      else                        w_taken = alu_result[0] ^ r_funct3[0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_kind         <= K_ILL;
      r_alu_control  <= OP_NONE;
      r_funct3       <= '0;
      r_rd           <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_out_result   <= '0;
      r_out_rd       <= '0;
      r_out_valid    <= 1'b0;
      r_out_wr_en    <= 1'b0;
      r_out_taken    <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_illegal  <= 1'b0;
      r_retired      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_kind        <= w_kind;
          r_alu_control <= w_ctrl;
          r_funct3      <= funct3;
          r_rd          <= rd;
          r_alu_a       <= (w_kind == K_ILL) ? '0 : rs1_data;
          r_alu_b       <= w_b;
          r_state       <= S_ISSUE;
        end
        S_ISSUE: begin
          r_out_result   <= (r_kind == K_ILL) ? '0 : alu_result;
          r_out_rd       <= r_rd;
          r_out_wr_en    <= (r_kind == K_ALU) && (r_rd != 5'd0);
          r_out_taken    <= w_taken;
          r_out_overflow <= ((r_alu_control == OP_ADD) || (r_alu_control == OP_SUB)) && alu_overflow;
          r_out_illegal  <= (r_kind == K_ILL);
          r_out_valid    <= 1'b1;
          r_state        <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_retired   <= r_retired + 16'd1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready         = (r_state == S_IDLE) && !rst;
  assign alu_a            = r_alu_a;
  assign alu_b            = r_alu_b;
  assign alu_control      = r_alu_control;
  assign out_valid        = r_out_valid;
  assign out_result       = r_out_result;
  assign out_rd           = r_out_rd;
  assign out_wr_en        = r_out_wr_en;
  assign out_branch_taken = r_out_taken;
  assign out_overflow     = r_out_overflow;
  assign out_illegal      = r_out_illegal;
  assign retired_count    = r_retired;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a behavioural ALU closes the loop and a
// vector table plus hand-written sequences check decode, handshake and reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_overflow, alu_zero, alu_equal;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en, out_branch_taken, out_overflow, out_illegal;
  logic [15:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_retired = 16'd0;

  always #5 clk = ~clk;

  execute_stage #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_equal(alu_equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_branch_taken(out_branch_taken), .out_overflow(out_overflow),
    .out_illegal(out_illegal), .retired_count(retired_count)
  );

  // Behavioural ALU. Overflow is driven high for non-add ops and code 0 returns
  // garbage, so the stage's own masking of both is exercised.
  always_comb begin
    alu_result   = 32'hDEADBEEF;
    alu_overflow = 1'b1;
    case (alu_control)
      4'd1:  alu_result = alu_a & alu_b;
      4'd2:  alu_result = alu_a | alu_b;
      4'd3:  alu_result = alu_a ^ alu_b;
      4'd5:  alu_result = alu_a << alu_b[4:0];
      4'd6:  alu_result = alu_a >> alu_b[4:0];
      4'd7:  alu_result = $signed(alu_a) >>> alu_b[4:0];
      4'd8: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'd12: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'd13: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd15: alu_result = {31'd0, alu_a < alu_b};
      default: ;
    endcase
    alu_zero  = (alu_result == 32'd0);
    alu_equal = (alu_a == alu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm;
    logic [3:0]  ctrl;
    logic [31:0] b, result;
    logic        wr, taken, ovf, ill;
  } vec_t;

  vec_t vecs[20];

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic f7,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] i);
    opcode = o; funct3 = f; funct7_5 = f7; rd = r; rs1_data = a; rs2_data = b; imm = i;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.opc, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check($sformatf("v%0d in_ready_idle", idx), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    drive(7'h7F, 3'h7, ~v.f7, ~v.rd, ~v.rs1, ~v.rs2, ~v.imm);
    check($sformatf("v%0d in_ready_issue", idx), {31'd0, in_ready}, 32'd0);
    check($sformatf("v%0d alu_control", idx), {28'd0, alu_control}, {28'd0, v.ctrl});
    check($sformatf("v%0d alu_a", idx), alu_a, v.ill ? 32'd0 : v.rs1);
    check($sformatf("v%0d alu_b", idx), alu_b, v.b);
    check($sformatf("v%0d out_valid_issue", idx), {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d out_valid", idx), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d out_result", idx), out_result, v.result);
    check($sformatf("v%0d out_rd", idx), {27'd0, out_rd}, {27'd0, v.rd});
    check($sformatf("v%0d out_wr_en", idx), {31'd0, out_wr_en}, {31'd0, v.wr});
    check($sformatf("v%0d out_taken", idx), {31'd0, out_branch_taken}, {31'd0, v.taken});
    check($sformatf("v%0d out_overflow", idx), {31'd0, out_overflow}, {31'd0, v.ovf});
    check($sformatf("v%0d out_illegal", idx), {31'd0, out_illegal}, {31'd0, v.ill});
    check($sformatf("v%0d alu_stable", idx), {28'd0, alu_control}, {28'd0, v.ctrl});
    @(negedge clk);
    exp_retired = exp_retired + 16'd1;
    check($sformatf("v%0d out_valid_clr", idx), {31'd0, out_valid}, 32'd0);
    check($sformatf("v%0d in_ready_back", idx), {31'd0, in_ready}, 32'd1);
    check($sformatf("v%0d retired", idx), {16'd0, retired_count}, {16'd0, exp_retired});
  endtask

  initial begin
    //          opc         f3    f7 rd     rs1           rs2           imm           ctrl   b             result        wr taken ovf ill
    vecs[0]  = '{7'b0110011, 3'd0, 0, 5'd3,  32'd5,        32'd7,        32'd0,        4'd8,  32'd7,        32'd12,       1, 0, 0, 0};
    vecs[1]  = '{7'b0110011, 3'd0, 1, 5'd4,  32'h80000000, 32'd1,        32'd0,        4'd12, 32'd1,        32'h7FFFFFFF, 1, 0, 1, 0};
    vecs[2]  = '{7'b1100011, 3'd4, 0, 5'd5,  32'hFFFFFFFF, 32'd1,        32'd0,        4'd13, 32'd1,        32'd1,        0, 1, 0, 0};
    vecs[3]  = '{7'b1100011, 3'd7, 0, 5'd5,  32'hFFFFFFFF, 32'd1,        32'd0,        4'd15, 32'd1,        32'd0,        0, 1, 0, 0};
    vecs[4]  = '{7'b0000011, 3'd2, 0, 5'd6,  32'd5,        32'd7,        32'd0,        4'd0,  32'd0,        32'd0,        0, 0, 0, 1};
    vecs[5]  = '{7'b0010011, 3'd0, 1, 5'd0,  32'd10,       32'd99,       32'hFFFFFFFD, 4'd8,  32'hFFFFFFFD, 32'd7,        0, 0, 0, 0};
    vecs[6]  = '{7'b0010011, 3'd5, 1, 5'd7,  32'h80000010, 32'd0,        32'h00000404, 4'd7,  32'h00000404, 32'hF8000001, 1, 0, 0, 0};
    vecs[7]  = '{7'b0110011, 3'd5, 0, 5'd8,  32'h80000010, 32'd4,        32'd0,        4'd6,  32'd4,        32'h08000001, 1, 0, 0, 0};
    vecs[8]  = '{7'b0110011, 3'd4, 0, 5'd9,  32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        4'd3,  32'h0FF00FF0, 32'hFF00FF00, 1, 0, 0, 0};
    vecs[9]  = '{7'b0010011, 3'd3, 0, 5'd10, 32'd3,        32'd0,        32'hFFFFFFFF, 4'd15, 32'hFFFFFFFF, 32'd1,        1, 0, 0, 0};
    vecs[10] = '{7'b1100011, 3'd0, 0, 5'd11, 32'd9,        32'd9,        32'd0,        4'd12, 32'd9,        32'd0,        0, 1, 0, 0};
    vecs[11] = '{7'b1100011, 3'd1, 0, 5'd11, 32'd9,        32'd9,        32'd0,        4'd12, 32'd9,        32'd0,        0, 0, 0, 0};
    vecs[12] = '{7'b1100011, 3'd2, 0, 5'd12, 32'd5,        32'd6,        32'd0,        4'd0,  32'd0,        32'd0,        0, 0, 0, 1};
    vecs[13] = '{7'b0110011, 3'd0, 0, 5'd13, 32'h7FFFFFFF, 32'd1,        32'd0,        4'd8,  32'd1,        32'h80000000, 1, 0, 1, 0};
    vecs[14] = '{7'b0110011, 3'd1, 0, 5'd14, 32'd1,        32'd31,       32'd0,        4'd5,  32'd31,       32'h80000000, 1, 0, 0, 0};
    vecs[15] = '{7'b0010011, 3'd7, 0, 5'd15, 32'hFFFF0000, 32'd0,        32'h00FF00FF, 4'd1,  32'h00FF00FF, 32'h00FF0000, 1, 0, 0, 0};
    vecs[16] = '{7'b0110011, 3'd6, 0, 5'd16, 32'd1,        32'd2,        32'd0,        4'd2,  32'd2,        32'd3,        1, 0, 0, 0};
    vecs[17] = '{7'b1100011, 3'd5, 0, 5'd17, 32'hFFFFFFFF, 32'd1,        32'd0,        4'd13, 32'd1,        32'd1,        0, 0, 0, 0};
    vecs[18] = '{7'b1100011, 3'd6, 0, 5'd18, 32'd1,        32'hFFFFFFFF, 32'd0,        4'd15, 32'hFFFFFFFF, 32'd1,        0, 1, 0, 0};
    vecs[19] = '{7'b0110011, 3'd2, 0, 5'd19, 32'hFFFFFFFB, 32'd3,        32'd0,        4'd13, 32'd3,        32'd1,        1, 0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(7'd0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst in_ready_low", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst alu_control", {28'd0, alu_control}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst retired", {16'd0, retired_count}, 32'd0);
    rst = 1'b0;
    #1 check("rst in_ready_release", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Backpressure: 5 stalled cycles in DONE, with in_valid waved to be ignored.
    @(negedge clk);
    drive(7'b0110011, 3'd0, 1'b0, 5'd9, 32'd100, 32'd23, 32'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    drive(7'b0110011, 3'd0, 1'b1, 5'd1, 32'd1, 32'd1, 32'd0);
    @(negedge clk);
    check("bp out_valid", {31'd0, out_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d out_result", c), out_result, 32'd123);
      check($sformatf("bp%0d out_rd", c), {27'd0, out_rd}, 32'd9);
      check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp%0d retired", c), {16'd0, retired_count}, {16'd0, exp_retired});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    exp_retired = exp_retired + 16'd1;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release retired", {16'd0, retired_count}, {16'd0, exp_retired});
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while waiting in DONE.
    out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rdone out_valid_pre", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    exp_retired = 16'd0;
    check("rdone out_valid", {31'd0, out_valid}, 32'd0);
    check("rdone retired", {16'd0, retired_count}, 32'd0);
    check("rdone out_result", out_result, 32'd0);
    check("rdone out_rd", {27'd0, out_rd}, 32'd0);
    check("rdone alu_control", {28'd0, alu_control}, 32'd0);
    check("rdone alu_b", alu_b, 32'd0);
    check("rdone in_ready_during", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1 check("rdone in_ready_after", {31'd0, in_ready}, 32'd1);

    // Reset while in ISSUE: the instruction must vanish without a handshake.
    @(negedge clk);
    drive(7'b0110011, 3'd0, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rissue%0d out_valid", c), {31'd0, out_valid}, 32'd0);
      check($sformatf("rissue%0d retired", c), {16'd0, retired_count}, 32'd0);
    end

    // Normal operation resumes after reset.
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
